// File: rtl/cond_pkg.sv
//------------------------------------------------------------------------------
// Module  : cond_pkg
// Brief   : Shared types for the ARM-style condition logic: condition codes,
//           NZCV flag bit positions and the flag register type.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package cond_pkg;

  // Bit positions inside the {N,Z,C,V} flag word.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

endpackage : cond_pkg

`default_nettype wire

// File: rtl/cond_check.sv
//------------------------------------------------------------------------------
// Module  : cond_check
// Brief   : Purely combinational evaluation of a 4-bit condition field against
//           an NZCV flag word. Stateless so a pipelined core can reuse it.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  flags_t     flags,
  output logic       ex
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;
  logic w_ge;

  assign w_n  = flags[FLAG_N];
  assign w_z  = flags[FLAG_Z];
  assign w_c  = flags[FLAG_C];
  assign w_v  = flags[FLAG_V];
  // Signed greater-or-equal is the shared term of GE/LT/GT/LE.
  assign w_ge = (w_n == w_v);

  always_comb begin
    ex = 1'b0;
    case (cond_e'(cond))
      EQ:      ex = w_z;
      NE:      ex = ~w_z;
      CS:      ex = w_c;
      CC:      ex = ~w_c;
      MI:      ex = w_n;
      PL:      ex = ~w_n;
      VS:      ex = w_v;
      VC:      ex = ~w_v;
      HI:      ex = w_c & ~w_z;
      LS:      ex = ~w_c | w_z;
      GE:      ex = w_ge;
      LT:      ex = ~w_ge;
      GT:      ex = ~w_z & w_ge;
      LE:      ex = w_z | ~w_ge;
      AL:      ex = 1'b1;
      NV:      ex = 1'b0;
      default: ex = 1'b0;
    endcase
  end

endmodule : cond_check

`default_nettype wire

// File: rtl/cond_logic_mc.sv
//------------------------------------------------------------------------------
// Module  : cond_logic_mc
// Brief   : NZCV flag register, latched CondEx verdict and write-enable gating
//           for the multi-cycle datapath. Optional sticky Q flag is enabled by
//           defining CONDLOGIC_QFLAG_EN.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module cond_logic_mc
  import cond_pkg::*;
#(
  parameter int FLAG_W = 4,
  parameter int COND_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COND_W-1:0] cond,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic [1:0]        flag_w,
  input  logic              cond_ld,
  input  logic              flush,
  input  logic              pc_s,
  input  logic              reg_w,
  input  logic              mem_w,
  input  logic              no_write,
  input  logic              q_clr,
  output logic              pc_write,
  output logic              reg_write,
  output logic              mem_write,
  output logic              cond_ex,
  output logic [FLAG_W-1:0] flags,
  output logic              q_flag
);

  flags_t r_flags;
  logic   r_cond_ex;
  logic   w_check;
  logic   w_nz_we;
  logic   w_cv_we;

  // The check always sees the stored flags, never the in-flight ALU result.
  cond_check u_cond_check (
    .cond  (cond),
    .flags (r_flags),
    .ex    (w_check)
  );

  // Flag writes are gated by the verdict held before this edge.
  assign w_nz_we = flag_w[1] & r_cond_ex;
  assign w_cv_we = flag_w[0] & r_cond_ex;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cond_ex <= 1'b0;
    end else if (flush) begin
      r_cond_ex <= 1'b0;
    end else if (cond_ld) begin
      r_cond_ex <= w_check;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= '0;
    end else begin
      if (w_nz_we) begin
        r_flags[FLAG_N] <= alu_flags[FLAG_N];
        r_flags[FLAG_Z] <= alu_flags[FLAG_Z];
      end
      if (w_cv_we) begin
        r_flags[FLAG_C] <= alu_flags[FLAG_C];
        r_flags[FLAG_V] <= alu_flags[FLAG_V];
      end
    end
  end

`ifdef CONDLOGIC_QFLAG_EN
  logic r_q_flag;

  // Set wins over clear so an overflow in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q_flag <= 1'b0;
    end else if (w_cv_we && alu_flags[FLAG_V]) begin
      r_q_flag <= 1'b1;
    end else if (q_clr) begin
      r_q_flag <= 1'b0;
    end
  end

  assign q_flag = r_q_flag;
`else
  logic w_unused_q_clr;

  assign w_unused_q_clr = q_clr;
  assign q_flag         = 1'b0;
`endif

  assign pc_write  = pc_s  & r_cond_ex;
  assign reg_write = reg_w & r_cond_ex & ~no_write;
  assign mem_write = mem_w & r_cond_ex;
  assign cond_ex   = r_cond_ex;
  assign flags     = r_flags;

endmodule : cond_logic_mc

`default_nettype wire

// File: tb/tb_cond_logic_mc.sv
//------------------------------------------------------------------------------
// Module  : tb_cond_logic_mc
// Brief   : Self-checking bench for cond_logic_mc: condition table plus
//           hand-written multi-cycle sequences.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cond_logic_mc;

  logic       clk;
  logic       reset;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic [1:0] flag_w;
  logic       cond_ld;
  logic       flush;
  logic       pc_s;
  logic       reg_w;
  logic       mem_w;
  logic       no_write;
  logic       q_clr;
  logic       pc_write;
  logic       reg_write;
  logic       mem_write;
  logic       cond_ex;
  logic [3:0] flags;
  logic       q_flag;

  cond_logic_mc dut (
    .clk       (clk),
    .reset     (reset),
    .cond      (cond),
    .alu_flags (alu_flags),
    .flag_w    (flag_w),
    .cond_ld   (cond_ld),
    .flush     (flush),
    .pc_s      (pc_s),
    .reg_w     (reg_w),
    .mem_w     (mem_w),
    .no_write  (no_write),
    .q_clr     (q_clr),
    .pc_write  (pc_write),
    .reg_write (reg_write),
    .mem_write (mem_write),
    .cond_ex   (cond_ex),
    .flags     (flags),
    .q_flag    (q_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cond;
    logic [3:0] flags;
    logic       exp;
  } vec_t;

  vec_t vecs[25];
  logic exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

`ifdef CONDLOGIC_QFLAG_EN
  localparam logic Q_EN = 1'b1;
`else
  localparam logic Q_EN = 1'b0;
`endif

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Latch a verdict; the expected value goes through the scoreboard queue.
  task automatic load_cond(input logic [3:0] c, input logic exp);
    cond    = c;
    cond_ld = 1'b1;
    exp_q.push_back(exp);
    tick();
    cond_ld = 1'b0;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else begin
      check("cond_ex", {3'b000, cond_ex}, {3'b000, exp_q.pop_front()});
    end
  endtask

  task automatic write_flags(input logic [1:0] fw, input logic [3:0] af);
    flag_w    = fw;
    alu_flags = af;
    tick();
    flag_w    = 2'b00;
  endtask

  task automatic set_flags(input logic [3:0] f);
    load_cond(4'b1110, 1'b1);
    write_flags(2'b11, f);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{4'd0,  4'b0100, 1'b1};
    vecs[1]  = '{4'd0,  4'b0000, 1'b0};
    vecs[2]  = '{4'd1,  4'b0100, 1'b0};
    vecs[3]  = '{4'd1,  4'b1011, 1'b1};
    vecs[4]  = '{4'd2,  4'b0010, 1'b1};
    vecs[5]  = '{4'd3,  4'b0010, 1'b0};
    vecs[6]  = '{4'd3,  4'b1101, 1'b1};
    vecs[7]  = '{4'd4,  4'b1000, 1'b1};
    vecs[8]  = '{4'd5,  4'b1000, 1'b0};
    vecs[9]  = '{4'd6,  4'b0001, 1'b1};
    vecs[10] = '{4'd7,  4'b0001, 1'b0};
    vecs[11] = '{4'd8,  4'b0010, 1'b1};
    vecs[12] = '{4'd8,  4'b0110, 1'b0};
    vecs[13] = '{4'd9,  4'b0110, 1'b1};
    vecs[14] = '{4'd9,  4'b0010, 1'b0};
    vecs[15] = '{4'd10, 4'b1001, 1'b1};
    vecs[16] = '{4'd10, 4'b1000, 1'b0};
    vecs[17] = '{4'd11, 4'b0001, 1'b1};
    vecs[18] = '{4'd11, 4'b0000, 1'b0};
    vecs[19] = '{4'd12, 4'b0000, 1'b1};
    vecs[20] = '{4'd12, 4'b0100, 1'b0};
    vecs[21] = '{4'd13, 4'b0100, 1'b1};
    vecs[22] = '{4'd13, 4'b1001, 1'b0};
    vecs[23] = '{4'd14, 4'b0000, 1'b1};
    vecs[24] = '{4'd15, 4'b1111, 1'b0};

    reset = 1'b0; cond = 4'd0; alu_flags = 4'd0; flag_w = 2'b00;
    cond_ld = 1'b0; flush = 1'b0; pc_s = 1'b0; reg_w = 1'b0;
    mem_w = 1'b0; no_write = 1'b0; q_clr = 1'b0;
    #1;
    check("rst_flags", flags, 4'b0000);
    check("rst_cond_ex", {3'b000, cond_ex}, 4'b0000);
    check("rst_q", {3'b000, q_flag}, 4'b0000);
    tick(); tick();
    reset = 1'b1;

    // Condition table
    for (int i = 0; i < 25; i++) begin
      set_flags(vecs[i].flags);
      check("tbl_flags", flags, vecs[i].flags);
      load_cond(vecs[i].cond, vecs[i].exp);
    end

    // Async reset from flags 1111 with live requests, no clock edge
    set_flags(4'b1111);
    check("pre_rst_flags", flags, 4'b1111);
    pc_s = 1'b1; reg_w = 1'b1; mem_w = 1'b1;
    #1;
    check("pre_rst_gates", {1'b0, pc_write, reg_write, mem_write}, 4'b0111);
    reset = 1'b0;
    #1;
    check("async_flags", flags, 4'b0000);
    check("async_gates", {cond_ex, pc_write, reg_write, mem_write}, 4'b0000);
    pc_s = 1'b0; reg_w = 1'b0; mem_w = 1'b0;
    tick();
    reset = 1'b1;

    // EQ with Z set, then no_write suppression
    set_flags(4'b0100);
    load_cond(4'd0, 1'b1);
    reg_w = 1'b1;
    #1;
    check("reg_write", {3'b000, reg_write}, 4'b0001);
    no_write = 1'b1;
    #1;
    check("no_write", {3'b000, reg_write}, 4'b0000);
    reg_w = 1'b0; no_write = 1'b0;

    // Independent NZ / CV halves
    write_flags(2'b10, 4'b1011);
    check("nz_only", flags, 4'b1000);
    write_flags(2'b01, 4'b1011);
    check("cv_only", flags, 4'b1011);

    // Failed condition blocks flag and memory/PC writes
    write_flags(2'b11, 4'b0100);
    load_cond(4'd1, 1'b0);
    mem_w = 1'b1; pc_s = 1'b1;
    #1;
    check("blocked_gates", {2'b00, mem_write, pc_write}, 4'b0000);
    write_flags(2'b11, 4'b1111);
    check("blocked_flags", flags, 4'b0100);
    mem_w = 1'b0; pc_s = 1'b0;

    // cond_ld and flag_w together: check sees pre-update flags
    set_flags(4'b1000);
    flag_w = 2'b11; alu_flags = 4'b1001;
    load_cond(4'd10, 1'b0);
    flag_w = 2'b00;
    check("same_cycle_flags", flags, 4'b1001);

    // flush beats cond_ld; write gated by old verdict still lands
    load_cond(4'b1110, 1'b1);
    flush = 1'b1; flag_w = 2'b11; alu_flags = 4'b0110;
    load_cond(4'b1110, 1'b0);
    flush = 1'b0; flag_w = 2'b00;
    check("flush_flags", flags, 4'b0110);

    // Sticky Q flag
    load_cond(4'b1110, 1'b1);
    write_flags(2'b01, 4'b0001);
    check("q_set", {3'b000, q_flag}, {3'b000, Q_EN});
    for (int k = 0; k < 3; k++) begin
      write_flags(2'b01, 4'b0000);
      check("q_sticky", {3'b000, q_flag}, {3'b000, Q_EN});
    end
    q_clr = 1'b1;
    tick();
    check("q_clr", {3'b000, q_flag}, 4'b0000);
    write_flags(2'b01, 4'b0001);
    check("q_set_prio", {3'b000, q_flag}, {3'b000, Q_EN});
    q_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_cond_logic_mc

`default_nettype wire

// File: doc/cond_logic_mc.md
Name: cond_logic_mc

Overview:
- Consumer end of the ALU flag interface in the multi-cycle ARM-style datapath.
- Holds the architectural NZCV flag register and updates it from the ALU's 4-bit flag output under FlagW control.
- Evaluates the instruction's 4-bit condition field against the stored flags, and latches the verdict (CondEx) for the whole multi-cycle instruction.
- Uses CondEx to gate PC, register-file and memory write enables issued by the main controller FSM.

Parameters:
- FLAG_W, 4, width of the flag bus; fixed order {N,Z,C,V}, bit 3 = N.
- COND_W, 4, width of the condition field.

Ports:
- clk  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- cond  in  4  instruction condition field Instr[31:28].
- alu_flags  in  4  {N,Z,C,V} from the ALU for the current operation.
- flag_w  in  2  [1] = write N,Z; [0] = write C,V; asserted in the ALU writeback state.
- cond_ld  in  1  pulse in the decode state; latches the CondEx verdict.
- flush  in  1  synchronous; clears latched CondEx to 0.
- pc_s  in  1  PC-write request from the controller.
- reg_w  in  1  register-write request.
- mem_w  in  1  memory-write request.
- no_write  in  1  compare-class op; suppresses register write.
- q_clr  in  1  clears the sticky Q flag (used only with the optional feature).
- pc_write  out  1  gated PC write.
- reg_write  out  1  gated register write.
- mem_write  out  1  gated memory write.
- cond_ex  out  1  latched condition verdict.
- flags  out  4  architectural {N,Z,C,V}.
- q_flag  out  1  sticky overflow flag.

Behaviour:
- Reset (async, reset = 0):
  - flags = 4'b0000.
  - cond_ex_q = 0.
  - q_flag = 0.
  - All gated outputs = 0, because they derive from cond_ex_q.
- Condition check is combinational on cond and the flag register, never on alu_flags:
  - EQ Z; NE ~Z
  - CS C; CC ~C
  - MI N; PL ~N
  - VS V; VC ~V
  - HI C&~Z; LS ~C|Z
  - GE N==V; LT N!=V
  - GT ~Z&(N==V); LE Z|(N!=V)
  - AL (1110) = 1; NV (1111) = 0.
- CondEx latch, evaluated at each rising edge:
  - flush = 1: cond_ex_q <= 0. flush has priority over cond_ld.
  - Else cond_ld = 1: cond_ex_q <= check(cond, flags).
  - Otherwise cond_ex_q holds.
  - Latency: 1 cycle from cond_ld to cond_ex.
- Flag update, at each rising edge:
  - flag_w[1] & cond_ex_q: N,Z <= alu_flags[3:2].
  - flag_w[0] & cond_ex_q: C,V <= alu_flags[1:0].
  - The two halves are independent.
  - New flags become visible on the cycle after the write.
- Simultaneous events:
  - cond_ld and flag_w in the same cycle: the check uses the pre-update flags; the write is gated by the old cond_ex_q.
  - flush with flag_w in the same cycle: the write is gated by the old cond_ex_q; it takes effect, then cond_ex_q clears.
- Gated outputs (combinational, zero latency from request):
  - pc_write = pc_s & cond_ex_q.
  - reg_write = reg_w & cond_ex_q & ~no_write.
  - mem_write = mem_w & cond_ex_q.
- Fetch-path exemption: the controller must not route PC+4 fetch increments through pc_s. The block has no knowledge of FSM state.
- Reset mid-instruction: everything clears immediately. No write escapes after reset asserts.
- No X propagation: every flags bit is always a registered, defined value.

Optional Feature:
- Macro: CONDLOGIC_QFLAG_EN.
- Defined:
  - q_flag sets on the edge where flag_w[0] & cond_ex_q & alu_flags[0].
  - q_flag is sticky; cleared only by reset or by a synchronous q_clr.
  - Set has priority over q_clr in the same cycle.
- Undefined: q_flag tied 0, q_clr ignored, no register inferred.

Decomposition:
- Package cond_pkg:
  - enum cond_e (EQ..NV, 4 bits).
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - typedef flags_t (logic [3:0]).
- One combinational sub-module cond_check: inputs cond and flags, output ex.
  - Also reusable by a future pipelined core.
- Flag and CondEx registers stay in cond_logic_mc.

Test Plan:
- Reset with flags previously 4'b1111 -> flags = 0000, cond_ex = 0, pc_write = reg_write = mem_write = 0 while reset is low, with no clock needed.
- Flags = 0100 (Z), cond = EQ, pulse cond_ld -> cond_ex = 1 next cycle. Then reg_w = 1 -> reg_write = 1. Set no_write = 1 -> reg_write = 0.
- cond_ex = 1, flag_w = 10, alu_flags = 1011 -> flags = 10 on NZ, CV unchanged (e.g. 10xx retains old CV). Then flag_w = 01 -> CV = 11.
- cond_ex = 0 (cond = NE with Z = 1), flag_w = 11, alu_flags = 1111, mem_w = pc_s = 1 -> flags unchanged, mem_write = pc_write = 0.
- Flags = 1000 (N = 1, V = 0), cond = GE with cond_ld, and simultaneously flag_w = 11 with alu_flags = 1001 -> cond_ex = 0, because the pre-update flags make N != V.
- With CONDLOGIC_QFLAG_EN: V-writing op with alu_flags[0] = 1 -> q_flag = 1 and it stays 1 across three later writes with V = 0. Pulse q_clr -> 0. Without the macro, q_flag stays 0.
